mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters, one per line: ADDR_WIDTH, 16, address width; DATA_WIDTH, 8, data width; TIMEOUT_CYCLES, 256, maximum DMA ownership cycles (used only with ARB_TIMEOUT_EN).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  input  1  clock, all state changes on posedge.
- reset  input  1  synchronous, active-high.
- cpu_mem_address  input  ADDR_WIDTH  CPU address.
- cpu_mem_read / cpu_mem_write  input  1 each  CPU strobes.
- cpu_mem_data_out  input  DATA_WIDTH  CPU write data.
- cpu_mem_data_in  output  DATA_WIDTH  read data to CPU.
- cpu_instr_complete  input  1  CPU instruction-boundary pulse.
- cpu_halt  input  1  CPU halted.
- cpu_hold  output  1  freezes CPU (clock enable low).
- dma_req  input  1  secondary master requests bus.
- dma_gnt  output  1  secondary master owns bus.
- dma_address  input  ADDR_WIDTH  secondary master address.
- dma_read / dma_write  input  1 each  secondary master strobes.
- dma_wdata  input  DATA_WIDTH  secondary master write data.
- dma_rdata  output  DATA_WIDTH  read data to secondary master.
- mem_address  output  ADDR_WIDTH  to memory.
- mem_read / mem_write  output  1 each  to memory.
- mem_wdata  output  DATA_WIDTH  to memory.
- mem_rdata  input  DATA_WIDTH  from memory.
- timeout_err  output  1  sticky DMA timeout flag.

Function
REQ-003 FSM states: CPU_OWN, HOLD, DMA_OWN, RELEASE; state register updates on posedge clk only.
REQ-004 CPU_OWN: mem_* = cpu_* combinationally; cpu_hold=0; dma_gnt=0.
REQ-005 CPU_OWN -> HOLD when dma_req=1 and (cpu_halt=1 or cpu_instr_complete=1) and owe_cpu=0.
REQ-006 HOLD: cpu_hold=1, dma_gnt=0, mem_read=mem_write=0 (one drain cycle); -> DMA_OWN if dma_req=1, else -> RELEASE.
REQ-007 DMA_OWN: mem_* = dma_*; dma_gnt=1; cpu_hold=1; -> RELEASE when dma_req=0.
REQ-008 RELEASE: cpu_hold=1, dma_gnt=0, strobes 0 for exactly one cycle; -> CPU_OWN; sets owe_cpu=1.
REQ-009 Grant latency: boundary+request at cycle N -> HOLD at N+1 -> dma_gnt=1 at N+2.
REQ-010 owe_cpu clears on cpu_instr_complete=1 in CPU_OWN; owe_cpu is ignored while cpu_halt=1 (immediate re-grant allowed).
REQ-011 Strobes from a non-owner never reach memory; non-owner address and data are don't-care.
REQ-012 Owner asserting read and write together: forward mem_write only, force mem_read=0.
REQ-013 cpu_mem_data_in and dma_rdata both driven from mem_rdata at all times; owner qualifies validity.
REQ-014 dma_req rising without a boundary: remain CPU_OWN indefinitely, no strobes suppressed.

Reset
REQ-015 On reset: state=CPU_OWN, cpu_hold=0, dma_gnt=0, owe_cpu=0, timeout_err=0, timeout counter=0.
REQ-016 Reset asserted in any state, including mid-DMA transfer, takes effect at the next edge; no memory strobe is issued by the arbiter during the reset cycle's aftermath beyond CPU pass-through.

Configuration
REQ-017 Macro ARB_TIMEOUT_EN defined: a counter counts DMA_OWN cycles; at TIMEOUT_CYCLES it forces DMA_OWN -> RELEASE, sets timeout_err (sticky until reset), and blocks re-grant until dma_req has been sampled 0 at least once.
REQ-018 Macro ARB_TIMEOUT_EN undefined: no counter, timeout_err tied 0, DMA ownership unbounded.

Verification
REQ-019 dma_req=1 at cycle 0, cpu_instr_complete pulse at cycle 3 -> cpu_hold=1 at 4, dma_gnt=1 at 5.
REQ-020 DMA_OWN, dma_write=1, dma_address=0x1234, dma_wdata=0x5A -> mem_write=1, mem_address=0x1234, mem_wdata=0x5A; simultaneous cpu_mem_write=1 not forwarded.
REQ-021 dma_req dropped at cycle 10 -> dma_gnt=0 at 11, one RELEASE cycle, cpu_hold=0 at 12; immediate dma_req re-grant only after next cpu_instr_complete.
REQ-022 cpu_halt=1, dma_req=1 -> granted without any cpu_instr_complete; repeated release/re-grant permitted.
REQ-023 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, dma_req held high -> dma_gnt drops after 4 owned cycles, timeout_err=1 until reset; no re-grant until dma_req low one cycle.
REQ-024 Reset asserted during DMA_OWN -> next cycle dma_gnt=0, cpu_hold=0, mem_* follows CPU.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between a CPU and a secondary (DMA) master.
//
// The CPU owns the bus by default. A DMA request is granted only at a CPU instruction
// boundary, or at any time while the CPU is halted. A one-cycle HOLD drain precedes the
// grant, and a one-cycle RELEASE follows it. After a release the CPU is owed one
// completed instruction before the next grant, unless the CPU is halted.
//
// Optional feature, macro ARB_TIMEOUT_EN: limits DMA ownership to TIMEOUT_CYCLES cycles,
// raises a sticky timeout_err, and blocks re-grant until dma_req has been seen low.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_mem_*, cpu_instr_complete   CPU bus side, instruction-boundary pulse
//   cpu_halt, cpu_hold              CPU halted status / CPU freeze
//   dma_req, dma_gnt                secondary master request / grant
//   dma_address/read/write/wdata    secondary master bus side
//   dma_rdata, cpu_mem_data_in      read data (both always carry mem_rdata)
//   mem_*                           shared memory port
//   timeout_err                     sticky DMA timeout flag (0 without ARB_TIMEOUT_EN)
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_address,
    input  logic                  cpu_mem_read,
    input  logic                  cpu_mem_write,
    input  logic [DATA_WIDTH-1:0] cpu_mem_data_out,
    output logic [DATA_WIDTH-1:0] cpu_mem_data_in,
    input  logic                  cpu_instr_complete,
    input  logic                  cpu_halt,
    output logic                  cpu_hold,
    input  logic                  dma_req,
    output logic                  dma_gnt,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic                  dma_read,
    input  logic                  dma_write,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        StCpuOwn  = 2'd0,
        StHold    = 2'd1,
        StDmaOwn  = 2'd2,
        StRelease = 2'd3
    } state_e;

    state_e r_state, w_state_next;
    logic   r_owe_cpu, w_owe_cpu_next;
    logic   w_tmo_hit;   // DMA ownership limit reached this cycle
    logic   w_blocked;   // re-grant blocked after a timeout

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_tmo_cnt;
    logic            r_tmo_block;
    logic            r_timeout_err;

    // r_tmo_cnt holds the number of DMA_OWN cycles already completed, so the limit is
    // reached during the TIMEOUT_CYCLES-th owned cycle. A request dropped in that same
    // cycle is an ordinary release, not a timeout.
    assign w_tmo_hit = (r_state == StDmaOwn) && dma_req &&
                       (r_tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));
    assign w_blocked   = r_tmo_block;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt     <= '0;
            r_tmo_block   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == StDmaOwn) r_tmo_cnt <= r_tmo_cnt + CntW'(1);
            else                     r_tmo_cnt <= '0;
            if (w_tmo_hit)    r_tmo_block <= 1'b1;
            else if (!dma_req) r_tmo_block <= 1'b0;
            if (w_tmo_hit) r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_tmo_hit   = 1'b0;
    assign w_blocked   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StCpuOwn;
            r_owe_cpu <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_owe_cpu <= w_owe_cpu_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_owe_cpu_next = r_owe_cpu;
        case (r_state)
            StCpuOwn: begin
                if (cpu_instr_complete) w_owe_cpu_next = 1'b0;
                // A halted CPU has no instruction to finish, so the debt is ignored.
                if (dma_req && (cpu_halt || cpu_instr_complete) &&
                    (!r_owe_cpu || cpu_halt) && !w_blocked) begin
                    w_state_next = StHold;
                end
            end
            StHold:   w_state_next = dma_req ? StDmaOwn : StRelease;
            StDmaOwn: if (!dma_req || w_tmo_hit) w_state_next = StRelease;
            StRelease: begin
                w_state_next   = StCpuOwn;
                w_owe_cpu_next = 1'b1;
            end
            default:  w_state_next = StCpuOwn;
        endcase
    end

    // Bus steering. HOLD and RELEASE keep the CPU address/data on the bus but issue no
    // strobes. Read+write together from the owner is treated as a write.
    always_comb begin
        mem_address = cpu_mem_address;
        mem_wdata   = cpu_mem_data_out;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        cpu_hold    = 1'b1;
        dma_gnt     = 1'b0;
        case (r_state)
            StCpuOwn: begin
                cpu_hold  = 1'b0;
                mem_write = cpu_mem_write;
                mem_read  = cpu_mem_read & ~cpu_mem_write;
            end
            StDmaOwn: begin
                dma_gnt     = 1'b1;
                mem_address = dma_address;
                mem_wdata   = dma_wdata;
                mem_write   = dma_write;
                mem_read    = dma_read & ~dma_write;
            end
            default: ;
        endcase
    end

    assign cpu_mem_data_in = mem_rdata;
    assign dma_rdata       = mem_rdata;

endmodule
